// File: rtl/enc_pkg.sv
// Shared types and defaults for the encoder sample controller.
// Overflow behaviour is selected with ENC_SAMPLE_SAT_EN (saturate if defined, wrap otherwise).
package enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2
    } enc_state_e;

    localparam int unsigned ENC_WINDOW_DEFAULT = 32'd50000;
    localparam int unsigned ENC_CW_DEFAULT     = 32'd8;

endpackage

// File: rtl/enc_window_timer.sv
// Window down-counter: load reloads WINDOW-1, dec counts down, zero flags the last window cycle.
module enc_window_timer
    import enc_pkg::*;
#(
    parameter int unsigned WINDOW = ENC_WINDOW_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int unsigned TW = $clog2(WINDOW);
    localparam logic [TW-1:0] RELOAD = TW'(WINDOW - 32'd1);

    logic [TW-1:0] cnt_q;

    // Timer register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (dec) begin
            cnt_q <= cnt_q - {{(TW-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/enc_sample_ctrl.sv
// Windowed quadrature step sampler with valid/ready output and sticky overrun.
// Define ENC_SAMPLE_SAT_EN for a saturating accumulator; the default build wraps.
module enc_sample_ctrl
    import enc_pkg::*;
#(
    parameter int unsigned WINDOW = ENC_WINDOW_DEFAULT,
    parameter int unsigned CW     = ENC_CW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    input  logic                 dir,
    output logic signed [CW-1:0] sample,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    input  logic                 clr_ovr,
    output logic                 busy
);

    function automatic logic [CW-1:0] acc_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
`ifdef ENC_SAMPLE_SAT_EN
        logic [CW:0] s;
        s = {a[CW-1], a} + {b[CW-1], b};
        if (s[CW] != s[CW-1]) begin
            acc_add = s[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
        end else begin
            acc_add = s[CW-1:0];
        end
`else
        acc_add = a + b;
`endif
    endfunction

    enc_state_e    state_q, state_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] step_c_s;
    logic          new_s;
    logic          zero_s;
    logic          tmr_load_s;
    logic          tmr_dec_s;

    assign step_c_s   = step ? (dir ? {{(CW-1){1'b0}}, 1'b1} : {CW{1'b1}}) : {CW{1'b0}};
    assign tmr_load_s = run & ((state_q == ST_ARM) | ((state_q == ST_COUNT) & zero_s));
    assign tmr_dec_s  = run & (state_q == ST_COUNT) & ~zero_s;

    enc_window_timer #(.WINDOW(WINDOW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load_s),
        .dec   (tmr_dec_s),
        .zero  (zero_s)
    );

    // Next-state: the timer-zero cycle's step closes the old window; the accumulator restarts at zero.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sample_d = sample_q;
        new_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COUNT;
                    acc_d   = step_c_s;
                end
            end
            ST_COUNT: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (zero_s) begin
                    sample_d = acc_add(acc_q, step_c_s);
                    acc_d    = {CW{1'b0}};
                    new_s    = 1'b1;
                end else begin
                    acc_d = acc_add(acc_q, step_c_s);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (new_s) begin
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A take in the same cycle as a new sample is not an overrun; set beats clear.
        if (new_s && valid_q && !ready) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= {CW{1'b0}};
            sample_q  <= {CW{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign sample  = sample_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_enc_sample_ctrl.sv
// Directed scoreboard bench: a WINDOW=10 instance for the main flow, a WINDOW=300 instance for overflow.
module tb_enc_sample_ctrl;

    logic       clk = 1'b0;
    logic       reset, run, step, dir, ready, clr_ovr;
    logic [7:0] s10, s300;
    logic       v10, o10, b10, v300, o300, b300;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [7:0] sb[$];

    enc_sample_ctrl #(.WINDOW(10), .CW(8)) u10 (
        .clk(clk), .reset(reset), .run(run), .step(step), .dir(dir),
        .sample(s10), .valid(v10), .ready(ready), .overrun(o10),
        .clr_ovr(clr_ovr), .busy(b10)
    );

    enc_sample_ctrl #(.WINDOW(300), .CW(8)) u300 (
        .clk(clk), .reset(reset), .run(run), .step(step), .dir(dir),
        .sample(s300), .valid(v300), .ready(ready), .overrun(o300),
        .clr_ovr(clr_ovr), .busy(b300)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for valid on the chosen instance, then pop and compare.
    task automatic wait_sample(input string tag, input bit big, input int limit);
        bit         seen;
        logic [7:0] exp;
        seen = 1'b0;
        for (int i = 0; i <= limit; i++) begin
            if ((big ? v300 : v10) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        exp = sb.pop_front();
        chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) chk(tag, {24'd0, (big ? s300 : s10)}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] sat_exp;
        reset = 1'b1; run = 1'b1; step = 1'b1; dir = 1'b1; ready = 1'b1; clr_ovr = 1'b0;
        cyc();
        step = 1'b0;
        cyc();
        chk("rst_sample",  {24'd0, s10}, 32'h0);
        chk("rst_valid",   {31'd0, v10}, 32'h0);
        chk("rst_overrun", {31'd0, o10}, 32'h0);
        chk("rst_busy",    {31'd0, b10}, 32'h0);
        chk("rst_busy300", {30'd0, b300, o300}, 32'h0);

        // +4 window starting from ARM
        reset = 1'b0;
        cyc();
        step = 1'b1; dir = 1'b1;
        cycn(4);
        step = 1'b0;
        chk("busy_run", {31'd0, b10}, 32'h1);
        sb.push_back(8'h04);
        wait_sample("up4", 1'b0, 30);

        // -3 window; valid must drop after one cycle with ready=1
        step = 1'b1; dir = 1'b0;
        cyc();
        chk("valid_one_cycle", {31'd0, v10}, 32'h0);
        cycn(2);
        step = 1'b0;
        sb.push_back(8'hFD);
        wait_sample("dn3", 1'b0, 20);

        // +2 taken, then +5 overwrites untaken +2
        step = 1'b1; dir = 1'b1;
        cycn(2);
        step = 1'b0;
        sb.push_back(8'h02);
        wait_sample("up2", 1'b0, 20);
        chk("ovr_before", {31'd0, o10}, 32'h0);
        ready = 1'b0;
        step = 1'b1;
        cycn(5);
        step = 1'b0;
        chk("hold_02", {24'd0, s10}, 32'h02);
        cycn(5);
        sb.push_back(8'h05);
        wait_sample("up5", 1'b0, 0);
        chk("ovr_set", {31'd0, o10}, 32'h1);
        chk("ovr_valid", {31'd0, v10}, 32'h1);
        clr_ovr = 1'b1; ready = 1'b1;
        cyc();
        clr_ovr = 1'b0;
        chk("ovr_clr", {31'd0, o10}, 32'h0);
        chk("valid_taken", {31'd0, v10}, 32'h0);

        // 2 steps, drop run 3 cycles (steps ignored), re-arm with 1 step
        step = 1'b1; dir = 1'b1;
        cyc();
        run = 1'b0;
        cycn(3);
        chk("idle_busy", {31'd0, b10}, 32'h0);
        chk("idle_valid", {31'd0, v10}, 32'h0);
        run = 1'b1; step = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        sb.push_back(8'h01);
        wait_sample("rearm1", 1'b0, 20);

        // step on the timer-zero cycle lands in the ending window
        cycn(9);
        step = 1'b1;
        cyc();
        step = 1'b0;
        sb.push_back(8'h01);
        wait_sample("last_cycle", 1'b0, 0);
        cyc();
        sb.push_back(8'h00);
        wait_sample("next_empty", 1'b0, 15);

        // reset wins over pending handshake
        ready = 1'b0; reset = 1'b1;
        cyc();
        chk("rstp_valid",  {31'd0, v10}, 32'h0);
        chk("rstp_sample", {24'd0, s10}, 32'h0);
        chk("rstp_busy",   {31'd0, b10}, 32'h0);

        // 200 up-steps in one WINDOW=300 window
        reset = 1'b0; ready = 1'b1;
        cyc();
        step = 1'b1; dir = 1'b1;
        cycn(200);
        step = 1'b0;
`ifdef ENC_SAMPLE_SAT_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'hC8;
`endif
        sb.push_back(sat_exp);
        wait_sample("ovf200", 1'b1, 400);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/enc_sample_ctrl.md
ENC_SAMPLE_CTRL -- requirements
Module: enc_sample_ctrl

Interface
REQ-001 Parameter WINDOW, default 50000, gate length in clk cycles per sample window (legal range 2..2^20).
REQ-002 Parameter CW, default 8, width of the signed step accumulator and sample output.
REQ-003 Port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port run  input  1  level; 1 enables windowed sampling, 0 idles the block.
REQ-006 Port step  input  1  one-cycle pulse per decoded quadrature edge.
REQ-007 Port dir  input  1  qualifies step: 1 = +1, 0 = -1.
REQ-008 Port sample  output  CW  signed net step count of the last completed window.
REQ-009 Port valid  output  1  sample holds an untaken result.
REQ-010 Port ready  input  1  consumer accepts sample when valid&ready.
REQ-011 Port overrun  output  1  sticky; an untaken sample was overwritten.
REQ-012 Port clr_ovr  input  1  one-cycle pulse; clears overrun.
REQ-013 Port busy  output  1  1 while in ARM or COUNT.

Function
REQ-014 The FSM SHALL have states IDLE, ARM and COUNT.
REQ-015 IDLE -> ARM when run=1; ARM -> COUNT unconditionally after one cycle; ARM or COUNT -> IDLE when run=0.
REQ-016 ARM SHALL load the window timer with WINDOW-1 and load the accumulator with the step contribution of that cycle (+1, -1 or 0).
REQ-017 In COUNT, each cycle SHALL decrement the timer and add the step contribution to the accumulator.
REQ-018 A step on the cycle the timer equals 0 SHALL be counted in the ending window.
REQ-019 When the timer equals 0 in COUNT, the next cycle SHALL see sample = final accumulator, valid=1, and the timer reloaded with WINDOW-1.
REQ-020 On that same window-end cycle, the accumulator SHALL restart with only the next window's contribution, so windows are back-to-back with no dead cycle.
REQ-021 Latency from the last window cycle to valid=1 SHALL be exactly one cycle.
REQ-022 valid&ready SHALL deassert valid on the next cycle, unless a new sample lands that cycle; then valid stays 1 with the new sample and overrun is unchanged.
REQ-023 A new sample landing while valid=1 and ready=0 SHALL overwrite sample and set overrun.
REQ-024 clr_ovr SHALL clear overrun unless a new overrun occurs in the same cycle; set wins.
REQ-025 run=0 mid-window SHALL discard the partial window; no sample is produced.
REQ-026 run=0 SHALL NOT alter sample, valid or overrun; handshake and clr_ovr stay functional in IDLE.
REQ-027 In IDLE, step SHALL be ignored.
REQ-028 Accumulator arithmetic SHALL be CW-bit two's complement; overflow behaviour is set by REQ-032/033.

Reset
REQ-029 reset SHALL force state=IDLE, accumulator=0, timer=0, sample=0, valid=0, overrun=0 and busy=0 on the next edge.
REQ-030 reset SHALL take priority over all inputs, including mid-window and during a pending handshake.

Configuration
REQ-031 Macro ENC_SAMPLE_SAT_EN SHALL select accumulator overflow behaviour.
REQ-032 With ENC_SAMPLE_SAT_EN defined, the accumulator SHALL saturate at +2^(CW-1)-1 and -2^(CW-1).
REQ-033 Without ENC_SAMPLE_SAT_EN, the accumulator SHALL wrap modulo 2^CW.

Structure
REQ-034 Package enc_pkg SHALL hold the FSM state enum and a default WINDOW constant.
REQ-035 The window down-counter SHALL be a sub-module enc_window_timer, with ports load, dec, zero and a WINDOW parameter.

Verification (WINDOW=10, CW=8)
REQ-036 Apply reset with run=1 and step toggling -> sample=0, valid=0, overrun=0, busy=0 on the next cycle.
REQ-037 Set run=1 and apply 4 steps with dir=1 in one window, ready=1 -> sample=8'h04 and valid=1 for exactly one cycle.
REQ-038 Apply 3 steps with dir=0 in one window -> sample=8'hFD (-3).
REQ-039 Set WINDOW=300 and apply 200 consecutive up-steps -> sample=8'h7F with ENC_SAMPLE_SAT_EN, 8'hC8 without it.
REQ-040 Hold ready=0 across windows of +2 then +5 -> sample=8'h05, overrun=1; pulse clr_ovr -> overrun=0.
REQ-041 Apply 2 steps, drop run for 3 cycles, reassert run, then apply 1 step -> next sample=8'h01.
